riscv_core_sequencer: RTL and testbench
=======================================

// Module: riscv_core_sequencer
// PURPOSE
//  Sits between the AXI4-Lite register slave and the RISC-V core/IMEM.
//  - Turns the register-level run and instruction-write ticks into core-level sequences: IMEM word writes,
//    a core reset pulse, and a bounded run of exactly N enabled core cycles.
//  - Returns idle/running/done status to the slave's status register.
// PARAMETERS
//  NUM_CYCLE_W     32  width of run-length count and elapsed-cycle counter
//  IMEM_ADDR_W     10  IMEM word-address width (1024 words)
//  DATA_W          32  instruction word width
//  CORE_RST_CYCLES 4   cycles core reset is held low before RUN (>=1)
// PORTS
//  S_AXI_ACLK     in  1            sole clock
//  S_AXI_ARESETN  in  1            async active-low reset
//  i_run          in  1            1-cycle start tick
//  i_num_cycle    in  NUM_CYCLE_W  requested enabled-cycle count N
//  i_mem_reset_n  in  1            level; 0 = hold IMEM and core in reset
//  i_instr_write  in  1            1-cycle IMEM write tick
//  i_instr_addr   in  32           IMEM byte address
//  i_instr_data   in  DATA_W       instruction word
//  o_idle         out 1            state==IDLE
//  o_running      out 1            state==RESET or RUN
//  o_done         out 1            1-cycle tick at end of a completed run
//  o_core_rst_n   out 1            core reset, active low
//  o_core_en      out 1            core clock-enable/stall release
//  o_imem_rst_n   out 1            registered copy of i_mem_reset_n
//  o_imem_we      out 1            IMEM write strobe, 1 cycle
//  o_imem_addr    out IMEM_ADDR_W  IMEM word address
//  o_imem_wdata   out DATA_W       IMEM write data
//  o_cycle_cnt    out NUM_CYCLE_W  enabled cycles elapsed in current/last run
//  o_wr_drop      out 1            sticky: an instruction write was discarded
// BEHAVIOUR
//  Reset (async, ARESETN=0), all outputs registered:
//   - state=IDLE, o_idle=1, o_core_rst_n=0, o_imem_rst_n=0; all other outputs 0.
//  FSM IDLE -> RESET -> RUN -> DONE -> IDLE.
//   - IDLE:  i_run && i_mem_reset_n -> latch N=i_num_cycle, clear o_cycle_cnt and o_wr_drop;
//            go to RESET.
//   - RESET: o_core_rst_n=0 for exactly CORE_RST_CYCLES cycles.
//            Then go to RUN if N!=0, else DONE.
//   - RUN:   o_core_rst_n=1, o_core_en=1, o_cycle_cnt++ each cycle.
//            Go to DONE in the cycle o_cycle_cnt reaches N; exactly N enabled cycles.
//   - DONE:  o_done=1 for one cycle, o_core_en=0, then IDLE.
//   - In IDLE, o_core_rst_n stays 1 after a completed run (core state preserved for readout).
//  Latency: run tick at cycle T:
//   - o_core_rst_n=0 in T+1..T+CORE_RST_CYCLES
//   - o_core_en=1 in T+CORE_RST_CYCLES+1..T+CORE_RST_CYCLES+N
//   - o_done at T+CORE_RST_CYCLES+N+1
//  IMEM write: i_instr_write at T in IDLE with i_mem_reset_n=1:
//   - at T+1: o_imem_we=1, o_imem_addr=i_instr_addr[IMEM_ADDR_W+1:2], o_imem_wdata=i_instr_data.
//   - Upper address bits are ignored (wrap).
//   - Write outside IDLE or with i_mem_reset_n=0: no strobe, o_wr_drop<=1.
//  Simultaneous i_run and i_instr_write in IDLE: the write is performed AND the run is accepted.
//  i_run outside IDLE: ignored. i_num_cycle changes after latch: ignored.
//  i_mem_reset_n=0 in any state:
//   - next cycle: state=IDLE, o_core_rst_n=0, o_core_en=0, no o_done.
//   - o_cycle_cnt holds its value.
//  o_cycle_cnt saturates at all-ones and never wraps.
// STRUCTURE
//  Package riscv_ctrl_pkg:
//   - state enum {IDLE,RESET,RUN,DONE}
//   - CORE_RST_CYCLES default and IMEM_ADDR_W default
//  Sub-module riscv_imem_wr_stage: registers the addr/data/we write path and drop detection.
//  FSM and counters stay in the top module.
// TESTING (CORE_RST_CYCLES=4)
//  1. Write addr 0x10, data 0x00000093 in IDLE -> one-cycle o_imem_we, o_imem_addr=4, o_imem_wdata=0x93.
//  2. Run N=5 at T -> o_core_rst_n low T+1..T+4, o_core_en T+5..T+9, o_done at T+10, o_cycle_cnt=5.
//  3. Run N=0 -> no o_core_en, o_done at T+5, o_cycle_cnt=0.
//  4. N=100, i_mem_reset_n->0 after 3 enabled cycles -> IDLE next cycle, no o_done, o_cycle_cnt=3.
//  5. i_instr_write and second i_run during RUN -> no o_imem_we, o_wr_drop=1, run unaffected;
//     next accepted run clears o_wr_drop.
//  6. ARESETN low mid-RUN -> outputs immediately at reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types and defaults for the core sequencer
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int NUM_CYCLE_W_DEF     = 32;
  localparam int IMEM_ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF          = 32;
  localparam int CORE_RST_CYCLES_DEF = 4;

endpackage

// File: rtl/riscv_core_sequencer_if.sv
// rtl/riscv_core_sequencer_if.sv - register-side control and core/IMEM-side outputs of the sequencer
interface riscv_core_sequencer_if
  import riscv_ctrl_pkg::*;
#(
  parameter int NUM_CYCLE_W = NUM_CYCLE_W_DEF,
  parameter int IMEM_ADDR_W = IMEM_ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
);
  logic                   i_run;
  logic [NUM_CYCLE_W-1:0] i_num_cycle;
  logic                   i_mem_reset_n;
  logic                   i_instr_write;
  logic [31:0]            i_instr_addr;
  logic [DATA_W-1:0]      i_instr_data;
  logic                   o_idle;
  logic                   o_running;
  logic                   o_done;
  logic                   o_core_rst_n;
  logic                   o_core_en;
  logic                   o_imem_rst_n;
  logic                   o_imem_we;
  logic [IMEM_ADDR_W-1:0] o_imem_addr;
  logic [DATA_W-1:0]      o_imem_wdata;
  logic [NUM_CYCLE_W-1:0] o_cycle_cnt;
  logic                   o_wr_drop;

  modport master (
    output i_run, i_num_cycle, i_mem_reset_n, i_instr_write, i_instr_addr, i_instr_data,
    input  o_idle, o_running, o_done, o_core_rst_n, o_core_en, o_imem_rst_n,
           o_imem_we, o_imem_addr, o_imem_wdata, o_cycle_cnt, o_wr_drop
  );

  modport slave (
    input  i_run, i_num_cycle, i_mem_reset_n, i_instr_write, i_instr_addr, i_instr_data,
    output o_idle, o_running, o_done, o_core_rst_n, o_core_en, o_imem_rst_n,
           o_imem_we, o_imem_addr, o_imem_wdata, o_cycle_cnt, o_wr_drop
  );
endinterface

// File: rtl/riscv_imem_wr_stage.sv
// rtl/riscv_imem_wr_stage.sv - registered IMEM write strobe/address/data and sticky drop flag
module riscv_imem_wr_stage #(
  parameter int IMEM_ADDR_W = 10,
  parameter int DATA_W      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   write_i,
  input  logic                   allow_i,
  input  logic                   clr_i,
  input  logic [IMEM_ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic                   we_o,
  output logic [IMEM_ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0]      data_o,
  output logic                   drop_o
);
  logic                   we_q, we_d;
  logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   drop_q, drop_d;

  // Accepted writes load addr/data for one strobe cycle; refused writes set the sticky drop flag
  always_comb begin
    we_d   = write_i && allow_i;
    addr_d = addr_q;
    data_d = data_q;
    drop_d = drop_q;
    if (we_d) begin
      addr_d = addr_i;
      data_d = data_i;
    end
    if (clr_i) begin
      drop_d = 1'b0;
    end else if (write_i && !allow_i) begin
      drop_d = 1'b1;
    end
  end

  // Write-path registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      drop_q <= 1'b0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      drop_q <= drop_d;
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign drop_o = drop_q;
endmodule

// File: rtl/riscv_core_sequencer.sv
// rtl/riscv_core_sequencer.sv - turns run/write ticks into core reset, bounded run and IMEM writes
module riscv_core_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int NUM_CYCLE_W     = NUM_CYCLE_W_DEF,
  parameter int IMEM_ADDR_W     = IMEM_ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int CORE_RST_CYCLES = CORE_RST_CYCLES_DEF
) (
  input logic                   S_AXI_ACLK,
  input logic                   S_AXI_ARESETN,
  riscv_core_sequencer_if.slave bus
);
  localparam int RW = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;

  seq_state_e             state_q, state_d;
  logic [NUM_CYCLE_W-1:0] n_q, n_d;
  logic [NUM_CYCLE_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   core_en_q, core_en_d;
  logic                   done_q, done_d;
  logic                   imem_rst_n_q;
  logic                   wr_allow;
  logic                   run_accept;
  logic                   unused_addr_bits;

  assign wr_allow   = (state_q == IDLE) && bus.i_mem_reset_n;
  assign run_accept = wr_allow && bus.i_run;

  // Byte address: only the word index inside the IMEM is used, the rest wraps
  assign unused_addr_bits = ^{bus.i_instr_addr[31:IMEM_ADDR_W+2], bus.i_instr_addr[1:0]};

  // Next state, run length latch, elapsed-cycle counter and core reset level
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    rcnt_d       = rcnt_q;
    core_rst_n_d = core_rst_n_q;
    if (!bus.i_mem_reset_n) begin
      state_d      = IDLE;
      core_rst_n_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_run) begin
            n_d          = bus.i_num_cycle;
            cnt_d        = '0;
            rcnt_d       = '0;
            core_rst_n_d = 1'b0;
            state_d      = RESET;
          end
        end
        RESET: begin
          if (rcnt_q == RW'(CORE_RST_CYCLES - 1)) begin
            core_rst_n_d = 1'b1;
            state_d      = (n_q != '0) ? RUN : DONE;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        RUN: begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + NUM_CYCLE_W'(1);
          if (cnt_d == n_q) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    core_en_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // FSM and counter registers; all outputs come straight from flops
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= IDLE;
      n_q          <= '0;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      core_rst_n_q <= 1'b0;
      core_en_q    <= 1'b0;
      done_q       <= 1'b0;
      imem_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      core_rst_n_q <= core_rst_n_d;
      core_en_q    <= core_en_d;
      done_q       <= done_d;
      imem_rst_n_q <= bus.i_mem_reset_n;
    end
  end

  riscv_imem_wr_stage #(
    .IMEM_ADDR_W (IMEM_ADDR_W),
    .DATA_W      (DATA_W)
  ) u_wr_stage (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .write_i (bus.i_instr_write),
    .allow_i (wr_allow),
    .clr_i   (run_accept),
    .addr_i  (bus.i_instr_addr[IMEM_ADDR_W+1:2]),
    .data_i  (bus.i_instr_data),
    .we_o    (bus.o_imem_we),
    .addr_o  (bus.o_imem_addr),
    .data_o  (bus.o_imem_wdata),
    .drop_o  (bus.o_wr_drop)
  );

  assign bus.o_idle       = (state_q == IDLE);
  assign bus.o_running    = (state_q == RESET) || (state_q == RUN);
  assign bus.o_done       = done_q;
  assign bus.o_core_rst_n = core_rst_n_q;
  assign bus.o_core_en    = core_en_q;
  assign bus.o_imem_rst_n = imem_rst_n_q;
  assign bus.o_cycle_cnt  = cnt_q;
endmodule

// File: tb/tb_riscv_core_sequencer.sv
// tb/tb_riscv_core_sequencer.sv - timeline-model and directed checks for riscv_core_sequencer
module tb_riscv_core_sequencer;
  localparam int R = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  riscv_core_sequencer_if bus_if ();

  riscv_core_sequencer #(
    .NUM_CYCLE_W     (32),
    .IMEM_ADDR_W     (10),
    .DATA_W          (32),
    .CORE_RST_CYCLES (R)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstn),
    .bus           (bus_if.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a run accepted in cycle t0 is described by offset k = cycle - t0
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_t0 = 0;
  longint      m_n = 0;
  bit          m_idle_rst_n = 1'b0;
  longint      m_hold = 0;
  bit          m_drop = 1'b0;
  bit          e_we = 1'b0;
  logic [9:0]  e_addr = '0;
  logic [31:0] e_data = '0;
  bit          e_imem_rst_n = 1'b0;

  function automatic longint cnt_at(input int c);
    int k;
    k = c - m_t0;
    if (k <= R) return 0;
    if (k <= R + m_n) return k - R - 1;
    return m_n;
  endfunction

  always @(posedge clk or negedge rstn) begin : mdl
    bit idle_now;
    if (!rstn) begin
      cyc = 0; m_active = 0; m_idle_rst_n = 0; m_hold = 0; m_drop = 0;
      e_we = 0; e_addr = '0; e_data = '0; e_imem_rst_n = 0;
    end else begin
      idle_now     = !m_active;
      e_imem_rst_n = bus_if.i_mem_reset_n;
      e_we         = bus_if.i_instr_write && idle_now && bus_if.i_mem_reset_n;
      if (e_we) begin
        e_addr = bus_if.i_instr_addr[11:2];
        e_data = bus_if.i_instr_data;
      end
      if (bus_if.i_instr_write && !e_we) m_drop = 1;
      if (!bus_if.i_mem_reset_n) begin
        if (m_active) begin
          m_hold   = cnt_at(cyc);
          m_active = 0;
        end
        m_idle_rst_n = 0;
      end else if (idle_now && bus_if.i_run) begin
        m_active = 1; m_t0 = cyc; m_n = longint'(bus_if.i_num_cycle);
        m_drop = 0; m_hold = 0;
      end
      cyc++;
      if (m_active && (cyc - m_t0) > R + m_n + 1) begin
        m_active = 0; m_idle_rst_n = 1; m_hold = m_n;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int     k;
    bit     ei, er, ed, ern, een;
    longint ec;
    if (rstn) begin
      ei = 1; er = 0; ed = 0; een = 0; ern = m_idle_rst_n; ec = m_hold;
      if (m_active) begin
        k = cyc - m_t0;
        ei = 0;
        if (k <= R) begin
          er = 1; ern = 0; ec = 0;
        end else if (k <= R + m_n) begin
          er = 1; ern = 1; een = 1; ec = k - R - 1;
        end else begin
          ed = 1; ern = 1; ec = m_n;
        end
      end
      chk("idle", bus_if.o_idle, ei);
      chk("running", bus_if.o_running, er);
      chk("done", bus_if.o_done, ed);
      chk("core_rst_n", bus_if.o_core_rst_n, ern);
      chk("core_en", bus_if.o_core_en, een);
      chk("cycle_cnt", bus_if.o_cycle_cnt, ec);
      chk("imem_rst_n", bus_if.o_imem_rst_n, e_imem_rst_n);
      chk("imem_we", bus_if.o_imem_we, e_we);
      chk("imem_addr", bus_if.o_imem_addr, e_addr);
      chk("imem_wdata", bus_if.o_imem_wdata, e_data);
      chk("wr_drop", bus_if.o_wr_drop, m_drop);
    end
  end

  // Issue a run tick and observe offsets relative to it; optional write+run injection at offset inj
  task automatic run_observe(input logic [31:0] n, input int inj, output int en_first,
                             output int en_cnt, output int done_off, output logic [31:0] cnt_done,
                             output bit rst_ok);
    @(negedge clk);
    bus_if.i_run = 1'b1;
    bus_if.i_num_cycle = n;
    en_first = -1; en_cnt = 0; done_off = -1; cnt_done = '0; rst_ok = 1;
    for (int k = 1; k <= 400 && done_off < 0; k++) begin
      @(negedge clk);
      if (k <= R && bus_if.o_core_rst_n !== 1'b0) rst_ok = 0;
      if (bus_if.o_core_en === 1'b1) begin
        en_cnt++;
        if (en_first < 0) en_first = k;
      end
      if (bus_if.o_done === 1'b1) begin
        done_off = k;
        cnt_done = bus_if.o_cycle_cnt;
      end
      bus_if.i_run = 1'b0;
      bus_if.i_instr_write = 1'b0;
      if (k == 1) bus_if.i_num_cycle = 32'hFFFF_FFFF;
      if (inj > 0 && k == inj) begin
        bus_if.i_run = 1'b1; bus_if.i_num_cycle = 32'd3;
        bus_if.i_instr_write = 1'b1; bus_if.i_instr_addr = 32'h40; bus_if.i_instr_data = 32'h55;
      end
    end
    if (done_off < 0) chk("run_timeout", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  initial begin : stim
    int ef, ec, dof;
    logic [31:0] cd;
    bit rok;
    bit seen;
    bus_if.i_run = 0; bus_if.i_num_cycle = '0; bus_if.i_mem_reset_n = 0;
    bus_if.i_instr_write = 0; bus_if.i_instr_addr = '0; bus_if.i_instr_data = '0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_idle", bus_if.o_idle, 1'b1);
    chk("rst_core_rst_n", bus_if.o_core_rst_n, 1'b0);
    chk("rst_imem_rst_n", bus_if.o_imem_rst_n, 1'b0);
    chk("rst_cycle_cnt", bus_if.o_cycle_cnt, 32'd0);
    #20 rstn = 1'b1;
    @(negedge clk);
    bus_if.i_mem_reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: IMEM write, then a wrapping address
    bus_if.i_instr_write = 1; bus_if.i_instr_addr = 32'h10; bus_if.i_instr_data = 32'h93;
    @(negedge clk);
    bus_if.i_instr_write = 0;
    chk("t1_we", bus_if.o_imem_we, 1'b1);
    chk("t1_addr", bus_if.o_imem_addr, 10'd4);
    chk("t1_data", bus_if.o_imem_wdata, 32'h93);
    @(negedge clk);
    chk("t1_we_pulse", bus_if.o_imem_we, 1'b0);
    bus_if.i_instr_write = 1; bus_if.i_instr_addr = 32'h0000_1FFC; bus_if.i_instr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_if.i_instr_write = 0;
    chk("t1_wrap_addr", bus_if.o_imem_addr, 10'h3FF);

    // Test 2: N=5
    run_observe(32'd5, 0, ef, ec, dof, cd, rok);
    chk("t2_rst_low", rok, 1'b1);
    chk("t2_en_first", ef, 5);
    chk("t2_en_cnt", ec, 5);
    chk("t2_done_off", dof, 10);
    chk("t2_cnt", cd, 32'd5);
    chk("t2_rst_n_kept", bus_if.o_core_rst_n, 1'b1);

    // Test 3: N=0
    run_observe(32'd0, 0, ef, ec, dof, cd, rok);
    chk("t3_en_cnt", ec, 0);
    chk("t3_done_off", dof, 5);
    chk("t3_cnt", cd, 32'd0);

    // Simultaneous run and write in IDLE
    @(negedge clk);
    bus_if.i_run = 1; bus_if.i_num_cycle = 32'd2;
    bus_if.i_instr_write = 1; bus_if.i_instr_addr = 32'h20; bus_if.i_instr_data = 32'hABC;
    @(negedge clk);
    bus_if.i_run = 0; bus_if.i_instr_write = 0;
    chk("sim_we", bus_if.o_imem_we, 1'b1);
    chk("sim_addr", bus_if.o_imem_addr, 10'd8);
    chk("sim_running", bus_if.o_running, 1'b1);
    chk("sim_drop", bus_if.o_wr_drop, 1'b0);
    repeat (R + 4) @(negedge clk);
    chk("sim_idle", bus_if.o_idle, 1'b1);

    // Test 5: write and run during RUN are refused, run unaffected
    run_observe(32'd20, 7, ef, ec, dof, cd, rok);
    chk("t5_en_cnt", ec, 20);
    chk("t5_done_off", dof, 25);
    chk("t5_cnt", cd, 32'd20);
    chk("t5_drop", bus_if.o_wr_drop, 1'b1);
    run_observe(32'd1, 0, ef, ec, dof, cd, rok);
    chk("t5_drop_clr", bus_if.o_wr_drop, 1'b0);
    chk("t5_done_off2", dof, 6);

    // Test 4: abort after 3 enabled cycles
    @(negedge clk);
    bus_if.i_run = 1; bus_if.i_num_cycle = 32'd100;
    @(negedge clk);
    bus_if.i_run = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus_if.o_cycle_cnt == 32'd3) seen = 1;
      else @(negedge clk);
    end
    chk("t4_reach3", seen, 1'b1);
    bus_if.i_mem_reset_n = 0;
    bus_if.i_instr_write = 1; bus_if.i_instr_addr = 32'h4; bus_if.i_instr_data = 32'h1;
    @(negedge clk);
    bus_if.i_instr_write = 0;
    chk("t4_idle", bus_if.o_idle, 1'b1);
    chk("t4_core_rst_n", bus_if.o_core_rst_n, 1'b0);
    chk("t4_done", bus_if.o_done, 1'b0);
    chk("t4_cnt", bus_if.o_cycle_cnt, 32'd3);
    chk("t4_drop", bus_if.o_wr_drop, 1'b1);
    bus_if.i_mem_reset_n = 1;
    repeat (3) @(negedge clk);
    chk("t4_cnt_hold", bus_if.o_cycle_cnt, 32'd3);
    chk("t4_rst_hold", bus_if.o_core_rst_n, 1'b0);

    // Test 6: async reset mid-RUN
    bus_if.i_run = 1; bus_if.i_num_cycle = 32'd50;
    @(negedge clk);
    bus_if.i_run = 0;
    repeat (8) @(negedge clk);
    chk("t6_pre_en", bus_if.o_core_en, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_idle", bus_if.o_idle, 1'b1);
    chk("t6_running", bus_if.o_running, 1'b0);
    chk("t6_en", bus_if.o_core_en, 1'b0);
    chk("t6_core_rst_n", bus_if.o_core_rst_n, 1'b0);
    chk("t6_cnt", bus_if.o_cycle_cnt, 32'd0);
    chk("t6_imem_rst_n", bus_if.o_imem_rst_n, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
